ias_core_p: RTL
===============

IAS_CORE_P -- requirements
Module: ias_core_p

Interface
REQ-001 SHALL have parameter WORD_W, default 40, memory/accumulator word width.
REQ-002 SHALL have parameter ADDR_W, default 12, address and PC width.
REQ-003 SHALL have parameter OPC_W, default 8, opcode width; WORD_W == 2*(OPC_W+ADDR_W) SHALL be enforced at elaboration.
REQ-004 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port mem_req, output, 1, memory transaction request.
REQ-007 SHALL have port mem_we, output, 1, 1=write, 0=read.
REQ-008 SHALL have port mem_addr, output, ADDR_W, transaction address.
REQ-009 SHALL have port mem_wdata, output, WORD_W, write data.
REQ-010 SHALL have port mem_ack, input, 1, transaction complete this cycle.
REQ-011 SHALL have port mem_rdata, input, WORD_W, read data, valid when mem_ack=1.
REQ-012 SHALL have port halted, output, 1, core stopped.
REQ-013 SHALL have ports pc (output, ADDR_W) and ac (output, WORD_W), architectural PC and accumulator.

Function
REQ-014 Instruction word SHALL hold left instruction in bits [WORD_W-1:WORD_W/2], right in [WORD_W/2-1:0]; each = opcode (upper OPC_W) + address (lower ADDR_W).
REQ-015 Opcodes SHALL be: 00000000 HALT, 00000001 LOAD M(X), 00000010 LOAD -M(X), 00000101 ADD, 00000110 SUB, 00100001 STOR, 00001101 JUMP left, 00001110 JUMP right, 00001111 JUMP+ left, 00010000 JUMP+ right; any other opcode SHALL execute as a 1-cycle NOP.
REQ-016 States SHALL be FETCH, EXEC, LOAD_IR, HALT.
REQ-017 FETCH: mem_req=1, mem_we=0, mem_addr=PC; on mem_ack capture MBR; normally IR/MAR <= left half, IBR <= right half, ibr_valid <= 1; if start_right set, IR/MAR <= right half, ibr_valid <= 0, PC <= PC+1, start_right <= 0; -> EXEC.
REQ-018 EXEC for LOAD/LOAD-/ADD/SUB: read mem_addr=MAR; on ack AC <= M, -M, AC+M, AC-M respectively, modulo 2^WORD_W.
REQ-019 EXEC for STOR: mem_we=1, mem_addr=MAR, mem_wdata=AC until ack.
REQ-020 mem_req, mem_we, mem_addr, mem_wdata SHALL stay stable while mem_req=1 and mem_ack=0; mem_req SHALL be 0 the cycle after an acked cycle unless a new transaction starts; mem_ack with mem_req=0 SHALL be ignored.
REQ-021 JUMP/JUMP+/HALT/NOP SHALL complete EXEC in 1 cycle with no memory transaction.
REQ-022 Jump taken: PC <= MAR, ibr_valid <= 0, start_right <= 1 for right variants; JUMP+ taken only when AC[WORD_W-1]=0, else behaves as NOP.
REQ-023 After EXEC: ibr_valid=1 -> LOAD_IR; else -> FETCH; HALT -> HALT.
REQ-024 LOAD_IR (1 cycle, no memory): IR/MAR <= IBR fields, ibr_valid <= 0, PC <= PC+1; -> EXEC.
REQ-025 PC SHALL wrap from 2^ADDR_W-1 to 0.
REQ-026 HALT state: halted=1, mem_req=0, held until rst.
REQ-027 Zero-wait latency: left memory instruction 2 cycles (FETCH+EXEC), right-half follower 2 cycles (LOAD_IR+EXEC); each wait cycle adds 1.

Reset
REQ-028 rst=1 SHALL immediately set: state FETCH, PC=0, AC=0, IR=0, MAR=0, MBR=0, IBR=0, ibr_valid=0, start_right=0, all outputs 0.
REQ-029 Reset during a pending transaction SHALL drop mem_req at once, discarding the transaction; first post-reset fetch SHALL be address 0.

Structure
REQ-030 Package ias_pkg SHALL hold opcode constants and the state enumeration.
REQ-031 Sub-module ias_alu (combinational load/negate/add/sub, WORD_W parameter) SHALL be the only child instance.

Verification
REQ-032 Mem[0]={LOAD 10, ADD 11}, Mem[1]={STOR 12, HALT}, Mem[10]=5, Mem[11]=7, zero-wait -> Mem[12]=12, ac=12, halted=1 at cycle 8, pc=2.
REQ-033 Same program, ack delayed 3 cycles per transaction -> request signals stable during wait, same final result.
REQ-034 Mem[0]={JUMP right 4, NOP}, Mem[4]={LOAD 10, LOAD 11}, Mem[5]={HALT, NOP} -> ac=7, Mem[10] never read.
REQ-035 AC=-1 (all ones), JUMP+ left 4 -> not taken, next instruction from IBR; AC=3 -> taken, pc=4.
REQ-036 ADDR_W=4, sequence of NOP words from 0 -> pc wraps 15 -> 0, fetch addr 0 after addr 15.
REQ-037 rst pulse while EXEC read waits for ack -> mem_req=0 same cycle, ac=0, next fetch addr 0.

Source files
------------

// File: rtl/ias_pkg.sv
// ---------------------------------------------------------------------------
// ias_pkg
// Shared definitions for the IAS-style accumulator core: instruction opcodes,
// the control state enumeration and the ALU operation select codes.
// Opcodes are kept as plain integers so the core can size them to whatever
// OPC_W it is built with.
// ---------------------------------------------------------------------------
package ias_pkg;

    localparam int unsigned OP_HALT      = 32'h00;
    localparam int unsigned OP_LOAD      = 32'h01;
    localparam int unsigned OP_LOAD_NEG  = 32'h02;
    localparam int unsigned OP_ADD       = 32'h05;
    localparam int unsigned OP_SUB       = 32'h06;
    localparam int unsigned OP_STOR      = 32'h21;
    localparam int unsigned OP_JUMP_L    = 32'h0D;
    localparam int unsigned OP_JUMP_R    = 32'h0E;
    localparam int unsigned OP_JUMPP_L   = 32'h0F;
    localparam int unsigned OP_JUMPP_R   = 32'h10;

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_EXEC    = 2'd1,
        ST_LOAD_IR = 2'd2,
        ST_HALT    = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        ALU_LOAD = 2'd0,
        ALU_NEG  = 2'd1,
        ALU_ADD  = 2'd2,
        ALU_SUB  = 2'd3
    } alu_op_t;

endpackage

// File: rtl/ias_alu.sv
// ---------------------------------------------------------------------------
// ias_alu
// Combinational accumulator ALU: produces the new accumulator value for the
// memory-operand instructions. All results wrap modulo 2^WORD_W.
//   op  : ALU_LOAD / ALU_NEG / ALU_ADD / ALU_SUB select
//   ac  : current accumulator
//   m   : memory operand (read data)
//   res : new accumulator value
// ---------------------------------------------------------------------------
module ias_alu
    import ias_pkg::*;
#(
    parameter int WORD_W = 40
) (
    input  logic [1:0]        op,
    input  logic [WORD_W-1:0] ac,
    input  logic [WORD_W-1:0] m,
    output logic [WORD_W-1:0] res
);

    logic signed [WORD_W-1:0] ac_s;
    logic signed [WORD_W-1:0] m_s;
    logic signed [WORD_W-1:0] res_s;

    assign ac_s = signed'(ac);
    assign m_s  = signed'(m);

    always_comb begin
        res_s = m_s;
        case (op)
            ALU_LOAD: res_s = m_s;
            ALU_NEG:  res_s = -m_s;
            ALU_ADD:  res_s = ac_s + m_s;
            ALU_SUB:  res_s = ac_s - m_s;
            default:  res_s = m_s;
        endcase
    end

    assign res = unsigned'(res_s);

endmodule

// File: rtl/ias_core_p.sv
// ---------------------------------------------------------------------------
// ias_core_p
// Multi-cycle IAS-style accumulator processor. Each memory word carries two
// instructions (left in the upper half, right in the lower half); the right
// one is parked in IBR and executed after the left without a second fetch.
//   clk, rst              : clock (rising edge), asynchronous active-high reset
//   mem_req/mem_we        : memory request, 1=write 0=read
//   mem_addr/mem_wdata    : transaction address and write data
//   mem_ack/mem_rdata     : transaction completes this cycle, read data
//   halted                : core has executed HALT
//   pc, ac                : architectural program counter and accumulator
// ---------------------------------------------------------------------------
module ias_core_p
    import ias_pkg::*;
#(
    parameter int WORD_W = 40,
    parameter int ADDR_W = 12,
    parameter int OPC_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic              halted,
    output logic [ADDR_W-1:0] pc,
    output logic [WORD_W-1:0] ac
);

    localparam int HALF_W = WORD_W / 2;

    generate
        if (WORD_W != 2 * (OPC_W + ADDR_W)) begin : g_bad_width
            $error("ias_core_p: WORD_W must equal 2*(OPC_W+ADDR_W)");
        end
    endgenerate

    state_t state, state_nx;

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] mar_q;
    logic [OPC_W-1:0]  ir_q;
    logic [WORD_W-1:0] ac_q;
    logic [WORD_W-1:0] mbr_q;
    logic [HALF_W-1:0] ibr_q;
    logic              ibr_valid;
    logic              start_right;

    // Instruction decode of IR
    logic       is_mem_rd;
    logic       is_stor;
    logic       is_jump;
    logic       jump_right;
    logic       jump_cond;
    logic       is_halt;
    logic [1:0] alu_op;
    logic       jump_taken;
    logic       exec_done;

    logic [WORD_W-1:0] alu_res;
    logic [HALF_W-1:0] rd_left;
    logic [HALF_W-1:0] rd_right;
    logic [HALF_W-1:0] fetch_half;

    // MBR is architectural state (visible in waveforms) that nothing inside
    // the core consumes.
    logic unused_mbr;
    assign unused_mbr = ^mbr_q;

    assign rd_left    = mem_rdata[WORD_W-1:HALF_W];
    assign rd_right   = mem_rdata[HALF_W-1:0];
    // After a taken right-variant jump the fetched word starts at its right half.
    assign fetch_half = start_right ? rd_right : rd_left;

    always_comb begin
        is_mem_rd  = 1'b0;
        is_stor    = 1'b0;
        is_jump    = 1'b0;
        jump_right = 1'b0;
        jump_cond  = 1'b0;
        is_halt    = 1'b0;
        alu_op     = ALU_LOAD;
        case (ir_q)
            OPC_W'(OP_LOAD):     begin is_mem_rd = 1'b1; alu_op = ALU_LOAD; end
            OPC_W'(OP_LOAD_NEG): begin is_mem_rd = 1'b1; alu_op = ALU_NEG;  end
            OPC_W'(OP_ADD):      begin is_mem_rd = 1'b1; alu_op = ALU_ADD;  end
            OPC_W'(OP_SUB):      begin is_mem_rd = 1'b1; alu_op = ALU_SUB;  end
            OPC_W'(OP_STOR):     is_stor = 1'b1;
            OPC_W'(OP_JUMP_L):   is_jump = 1'b1;
            OPC_W'(OP_JUMP_R):   begin is_jump = 1'b1; jump_right = 1'b1; end
            OPC_W'(OP_JUMPP_L):  begin is_jump = 1'b1; jump_cond = 1'b1; end
            OPC_W'(OP_JUMPP_R):  begin is_jump = 1'b1; jump_cond = 1'b1; jump_right = 1'b1; end
            OPC_W'(OP_HALT):     is_halt = 1'b1;
            default: ;
        endcase
    end

    // A conditional jump with a negative accumulator falls through like a NOP.
    assign jump_taken = is_jump && (!jump_cond || !ac_q[WORD_W-1]);
    assign exec_done  = !(is_mem_rd || is_stor) || mem_ack;

    ias_alu #(.WORD_W(WORD_W)) u_alu (
        .op  (alu_op),
        .ac  (ac_q),
        .m   (mem_rdata),
        .res (alu_res)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_FETCH;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            ST_FETCH: begin
                if (mem_ack) state_nx = ST_EXEC;
            end
            ST_EXEC: begin
                if (exec_done) begin
                    if (is_halt)         state_nx = ST_HALT;
                    else if (jump_taken) state_nx = ST_FETCH;
                    else if (ibr_valid)  state_nx = ST_LOAD_IR;
                    else                 state_nx = ST_FETCH;
                end
            end
            ST_LOAD_IR: state_nx = ST_EXEC;
            ST_HALT:    state_nx = ST_HALT;
            default:    state_nx = ST_FETCH;
        endcase
    end

    // Output logic. Everything is a function of registered state, so request
    // signals hold steady while a transaction waits; rst forces them low at once.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        halted    = 1'b0;
        if (!rst) begin
            case (state)
                ST_FETCH: begin
                    mem_req  = 1'b1;
                    mem_addr = pc_q;
                end
                ST_EXEC: begin
                    if (is_mem_rd) begin
                        mem_req  = 1'b1;
                        mem_addr = mar_q;
                    end else if (is_stor) begin
                        mem_req   = 1'b1;
                        mem_we    = 1'b1;
                        mem_addr  = mar_q;
                        mem_wdata = ac_q;
                    end
                end
                ST_HALT: halted = 1'b1;
                default: ;
            endcase
        end
    end

    // Architectural registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q        <= '0;
            ac_q        <= '0;
            ir_q        <= '0;
            mar_q       <= '0;
            mbr_q       <= '0;
            ibr_q       <= '0;
            ibr_valid   <= 1'b0;
            start_right <= 1'b0;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (mem_ack) begin
                        mbr_q <= mem_rdata;
                        ir_q  <= fetch_half[HALF_W-1 -: OPC_W];
                        mar_q <= fetch_half[ADDR_W-1:0];
                        if (start_right) begin
                            ibr_valid   <= 1'b0;
                            pc_q        <= pc_q + ADDR_W'(1);
                            start_right <= 1'b0;
                        end else begin
                            ibr_q     <= rd_right;
                            ibr_valid <= 1'b1;
                        end
                    end
                end
                ST_EXEC: begin
                    if (is_mem_rd && mem_ack) begin
                        mbr_q <= mem_rdata;
                        ac_q  <= alu_res;
                    end
                    if (jump_taken) begin
                        pc_q        <= mar_q;
                        ibr_valid   <= 1'b0;
                        start_right <= jump_right;
                    end
                end
                ST_LOAD_IR: begin
                    ir_q      <= ibr_q[HALF_W-1 -: OPC_W];
                    mar_q     <= ibr_q[ADDR_W-1:0];
                    ibr_valid <= 1'b0;
                    pc_q      <= pc_q + ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign pc = pc_q;
    assign ac = ac_q;

endmodule
